// File: rtl/hnf_txreq_arb_pkg.sv
// Shared CHI request-channel definitions used by the home-node TXREQ path.
package hnf_txreq_arb_pkg;

  localparam int CHI_MAX_LCRD = 15;

  localparam logic [6:0] CHI_REQ_READNOSNP      = 7'h04;
  localparam logic [6:0] CHI_REQ_WRITENOSNPFULL = 7'h1D;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [7:0]  txn_id;
    logic [6:0]  opcode;
    logic [2:0]  size;
    logic [31:0] addr;
  } reqflit_t;

  typedef enum logic {
    PRI_RD = 1'b0,
    PRI_WB = 1'b1
  } rr_pri_e;

  // Round-robin: after a grant, priority goes to the requester that lost.
  function automatic rr_pri_e rr_next(input logic gnt_rd);
    return gnt_rd ? PRI_WB : PRI_RD;
  endfunction

endpackage

// File: rtl/hnf_txreq_arb_chk.sv
// Simulation-only protocol checks on the TXREQ arbiter boundary.
module hnf_txreq_arb_chk #(
  parameter int CRD_W = 4
) (
  input logic             clock,
  input logic             reset,
  input logic             rd_valid,
  input logic             wb_valid,
  input logic             rd_ready,
  input logic             wb_ready,
  input logic             TXREQFLITV,
  input logic [CRD_W-1:0] crd_cnt
);

  a_no_flitv_without_crd: assert property (@(posedge clock) disable iff (reset)
    !(TXREQFLITV && (crd_cnt == {CRD_W{1'b0}})));

  a_rd_ready_needs_valid: assert property (@(posedge clock) disable iff (reset)
    rd_ready |-> rd_valid);

  a_wb_ready_needs_valid: assert property (@(posedge clock) disable iff (reset)
    wb_ready |-> wb_valid);

  a_single_grant: assert property (@(posedge clock) disable iff (reset)
    !(rd_ready && wb_ready));

endmodule

// File: rtl/hnf_txreq_arb_lcrd.sv
// CHI link-layer credit counter: one credit in per LCRDV, one out per sent flit,
// saturating at MAX_CRD with a sticky overflow flag.
module chi_lcrd_counter #(
  parameter int MAX_CRD = 15,
  parameter int CRD_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             crd_inc,
  input  logic             crd_dec,
  output logic [CRD_W-1:0] crd_cnt,
  output logic             crd_err
);

  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(MAX_CRD);
  localparam logic [CRD_W-1:0] CRD_ZERO = {CRD_W{1'b0}};
  localparam logic [CRD_W-1:0] CRD_ONE  = {{(CRD_W-1){1'b0}}, 1'b1};

  logic [CRD_W-1:0] cnt_r;
  logic [CRD_W-1:0] cnt_nxt_s;
  logic             err_r;
  logic             err_nxt_s;

  // Next count; simultaneous return and spend cancel out even at MAX_CRD.
  always_comb begin
    cnt_nxt_s = cnt_r;
    err_nxt_s = err_r;
    case ({crd_inc, crd_dec})
      2'b10: begin
        if (cnt_r == CRD_MAX) begin
          err_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CRD_ONE;
        end
      end
      2'b01: begin
        if (cnt_r != CRD_ZERO) begin
          cnt_nxt_s = cnt_r - CRD_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // Count and sticky error registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= CRD_ZERO;
      err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      err_r <= err_nxt_s;
    end
  end

  assign crd_cnt = cnt_r;
  assign crd_err = err_r;

endmodule

// File: rtl/hnf_txreq_arb.sv
// HN-F TXREQ arbiter: round-robin between the read and writeback request paths,
// gated by CHI link credits, with a registered flit output toward the SN-F.
module hnf_txreq_arb
  import hnf_txreq_arb_pkg::*;
#(
  parameter int MAX_CRD = CHI_MAX_LCRD,
  parameter int CRD_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rd_valid,
  input  reqflit_t         rd_flit,
  output logic             rd_ready,
  input  logic             wb_valid,
  input  reqflit_t         wb_flit,
  output logic             wb_ready,
  output reqflit_t         TXREQFLIT,
  output logic             TXREQFLITV,
  output logic             TXREQFLITPEND,
  input  logic             TXREQLCRDV,
  output logic [CRD_W-1:0] crd_cnt,
  output logic             crd_err
);

  rr_pri_e          pri_r;
  reqflit_t         flit_r;
  logic             flitv_r;
  logic [CRD_W-1:0] crd_cnt_s;
  logic             crd_err_s;
  logic             eligible_s;
  logic             gnt_rd_s;
  logic             gnt_wb_s;

  chi_lcrd_counter #(
    .MAX_CRD (MAX_CRD),
    .CRD_W   (CRD_W)
  ) u_lcrd (
    .clock   (clock),
    .reset   (reset),
    .crd_inc (TXREQLCRDV),
    .crd_dec (flitv_r),
    .crd_cnt (crd_cnt_s),
    .crd_err (crd_err_s)
  );

  // The flit on the wire this cycle has already claimed one credit; a credit
  // returning this cycle only counts from the next one.
  always_comb begin
    eligible_s = (crd_cnt_s > {{(CRD_W-1){1'b0}}, flitv_r});
  end

  // Round-robin grant; a lone requester wins regardless of the pointer.
  always_comb begin
    gnt_rd_s = 1'b0;
    gnt_wb_s = 1'b0;
    if (reset || !eligible_s) begin
      gnt_rd_s = 1'b0;
      gnt_wb_s = 1'b0;
    end else if (rd_valid && wb_valid) begin
      gnt_rd_s = (pri_r == PRI_RD);
      gnt_wb_s = (pri_r == PRI_WB);
    end else if (rd_valid) begin
      gnt_rd_s = 1'b1;
    end else if (wb_valid) begin
      gnt_wb_s = 1'b1;
    end else begin
      gnt_rd_s = 1'b0;
      gnt_wb_s = 1'b0;
    end
  end

  // Priority pointer and output flit register; the flit holds when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pri_r   <= PRI_RD;
      flitv_r <= 1'b0;
      flit_r  <= '0;
    end else begin
      flitv_r <= gnt_rd_s | gnt_wb_s;
      if (gnt_rd_s) begin
        flit_r <= rd_flit;
        pri_r  <= rr_next(1'b1);
      end else if (gnt_wb_s) begin
        flit_r <= wb_flit;
        pri_r  <= rr_next(1'b0);
      end else begin
        flit_r <= flit_r;
        pri_r  <= pri_r;
      end
    end
  end

  assign rd_ready      = gnt_rd_s;
  assign wb_ready      = gnt_wb_s;
  assign TXREQFLIT     = flit_r;
  assign TXREQFLITV    = flitv_r;
  assign TXREQFLITPEND = rd_valid | wb_valid;
  assign crd_cnt       = crd_cnt_s;
  assign crd_err       = crd_err_s;

endmodule

// File: tb/tb_hnf_txreq_arb.sv
// Directed and random stimulus for hnf_txreq_arb against a cycle-level
// behavioural model of credits, round-robin priority and the output flit.
module tb_hnf_txreq_arb;
  import hnf_txreq_arb_pkg::*;

  localparam int MAXC  = 15;
  localparam int CRD_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             rd_valid = 1'b0;
  reqflit_t         rd_flit = '0;
  logic             rd_ready;
  logic             wb_valid = 1'b0;
  reqflit_t         wb_flit = '0;
  logic             wb_ready;
  reqflit_t         TXREQFLIT;
  logic             TXREQFLITV;
  logic             TXREQFLITPEND;
  logic             TXREQLCRDV = 1'b0;
  logic [CRD_W-1:0] crd_cnt;
  logic             crd_err;

  always #5 clock = ~clock;

  hnf_txreq_arb #(.MAX_CRD(MAXC), .CRD_W(CRD_W)) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_flit(rd_flit), .rd_ready(rd_ready),
    .wb_valid(wb_valid), .wb_flit(wb_flit), .wb_ready(wb_ready),
    .TXREQFLIT(TXREQFLIT), .TXREQFLITV(TXREQFLITV), .TXREQFLITPEND(TXREQFLITPEND),
    .TXREQLCRDV(TXREQLCRDV), .crd_cnt(crd_cnt), .crd_err(crd_err)
  );

  hnf_txreq_arb_chk #(.CRD_W(CRD_W)) u_chk (
    .clock(clock), .reset(reset), .rd_valid(rd_valid), .wb_valid(wb_valid),
    .rd_ready(rd_ready), .wb_ready(wb_ready), .TXREQFLITV(TXREQFLITV), .crd_cnt(crd_cnt)
  );

  // Reference model state: credits as a plain integer, who has priority,
  // and what the link should be showing this cycle.
  int       m_crd;
  bit       m_err;
  bit       m_pri_rd;
  bit       m_flitv;
  reqflit_t m_flit;
  bit       g_rd_gnt;
  bit       g_wb_gnt;
  int       n_assert = 0;
  int       n_fail   = 0;
  int       n_flitv_seen;
  logic [6:0] q_opc[$];
  logic [7:0] rd_txn = 8'd0;
  logic [7:0] wb_txn = 8'd128;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic reqflit_t mk_flit(input logic [6:0] opc, input logic [7:0] txn);
    reqflit_t f;
    f.qos    = 4'($urandom);
    f.tgt_id = 7'($urandom);
    f.src_id = 7'($urandom);
    f.txn_id = txn;
    f.opcode = opc;
    f.size   = 3'($urandom);
    f.addr   = $urandom;
    return f;
  endfunction

  task automatic model_reset();
    m_crd = 0; m_err = 1'b0; m_pri_rd = 1'b1; m_flitv = 1'b0; m_flit = '0;
  endtask

  // One clock cycle: check all outputs against the model, then advance it.
  task automatic step();
    bit elig, e_rd, e_wb;
    #1;
    elig = !reset && ((m_crd - int'(m_flitv)) > 0);
    e_rd = elig && rd_valid && (!wb_valid || m_pri_rd);
    e_wb = elig && wb_valid && (!rd_valid || !m_pri_rd);
    chk("rd_ready", 96'(rd_ready), 96'(e_rd));
    chk("wb_ready", 96'(wb_ready), 96'(e_wb));
    chk("pend", 96'(TXREQFLITPEND), 96'(rd_valid | wb_valid));
    chk("flitv", 96'(TXREQFLITV), 96'(m_flitv));
    chk("flit", 96'(TXREQFLIT), 96'(m_flit));
    chk("crd_cnt", 96'(crd_cnt), 96'(m_crd));
    chk("crd_err", 96'(crd_err), 96'(m_err));
    if (TXREQFLITV === 1'b1) begin
      n_flitv_seen++;
      q_opc.push_back(TXREQFLIT.opcode);
    end
    g_rd_gnt = e_rd;
    g_wb_gnt = e_wb;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      m_crd = m_crd + int'(TXREQLCRDV) - int'(m_flitv);
      if (m_crd > MAXC) begin
        m_crd = MAXC;
        m_err = 1'b1;
      end
      m_flitv = e_rd || e_wb;
      if (e_rd) begin
        m_flit = rd_flit; m_pri_rd = 1'b0;
      end else if (e_wb) begin
        m_flit = wb_flit; m_pri_rd = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  // After an accepted flit the requester presents a fresh one.
  task automatic refresh();
    if (g_rd_gnt) begin rd_flit = mk_flit(CHI_REQ_READNOSNP, rd_txn); rd_txn++; end
    if (g_wb_gnt) begin wb_flit = mk_flit(CHI_REQ_WRITENOSNPFULL, wb_txn); wb_txn++; end
  endtask

  task automatic idle_inputs();
    rd_valid = 1'b0; wb_valid = 1'b0; TXREQLCRDV = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic give_credits(input int n);
    TXREQLCRDV = 1'b1;
    repeat (n) step();
    TXREQLCRDV = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    model_reset();

    // Reset state with requests and a credit present: nothing granted or kept.
    rd_flit = mk_flit(CHI_REQ_READNOSNP, rd_txn); rd_txn++;
    wb_flit = mk_flit(CHI_REQ_WRITENOSNPFULL, wb_txn); wb_txn++;
    rd_valid = 1'b1; wb_valid = 1'b1; TXREQLCRDV = 1'b1;
    step();
    idle_inputs();
    step();

    // Three credits, then rd held five cycles: three back-to-back flits.
    give_credits(3);
    n_flitv_seen = 0;
    rd_valid = 1'b1;
    repeat (5) begin step(); refresh(); end
    rd_valid = 1'b0;
    step();
    chk("s1_flit_count", 96'(n_flitv_seen), 96'd3);
    chk("s1_crd_zero", 96'(crd_cnt), 96'd0);

    // Four credits, both requesters valid: strict rd/wb alternation.
    do_reset();
    give_credits(4);
    q_opc.delete();
    rd_valid = 1'b1; wb_valid = 1'b1;
    repeat (6) begin step(); refresh(); end
    idle_inputs();
    step();
    chk("s2_flit_count", 96'(q_opc.size()), 96'd4);
    for (int i = 0; i < q_opc.size() && i < 4; i++) begin
      chk("s2_order", 96'(q_opc[i]), 96'((i % 2 == 0) ? CHI_REQ_READNOSNP : CHI_REQ_WRITENOSNPFULL));
    end

    // One credit; credit return coincides with the outgoing flit.
    do_reset();
    give_credits(1);
    rd_valid = 1'b1;
    step(); refresh();
    TXREQLCRDV = 1'b1;
    step(); refresh();
    TXREQLCRDV = 1'b0;
    chk("s3_crd_one", 96'(crd_cnt), 96'd1);
    step(); refresh();
    idle_inputs();
    repeat (2) step();

    // No credits, rd waiting; a credit pulse enables the grant a cycle later.
    do_reset();
    rd_valid = 1'b1;
    step();
    TXREQLCRDV = 1'b1;
    step(); refresh();
    TXREQLCRDV = 1'b0;
    step(); refresh();
    rd_valid = 1'b0;
    repeat (2) step();

    // Sixteen credits with no traffic: saturation and sticky error.
    do_reset();
    give_credits(16);
    repeat (10) step();
    chk("s5_crd_max", 96'(crd_cnt), 96'(MAXC));
    chk("s5_err_sticky", 96'(crd_err), 96'd1);

    // Reset lands on a would-be grant cycle; pointer returns to rd.
    do_reset();
    give_credits(3);
    rd_valid = 1'b1;
    step(); refresh();
    reset = 1'b1; wb_valid = 1'b1;
    step();
    reset = 1'b0;
    step();
    give_credits(1);
    q_opc.delete();
    step(); refresh();
    idle_inputs();
    step();
    chk("s6_ptr_rd", 96'((q_opc.size() > 0) ? q_opc[0] : 7'h7F), 96'(CHI_REQ_READNOSNP));

    // Random traffic: credit returns, drops without grant, occasional reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      TXREQLCRDV = ($urandom_range(0, 99) < 30);
      if (!rd_valid || g_rd_gnt || ($urandom_range(0, 99) < 5)) begin
        rd_valid = ($urandom_range(0, 99) < 50);
        rd_flit = mk_flit(CHI_REQ_READNOSNP, rd_txn); rd_txn++;
      end
      if (!wb_valid || g_wb_gnt || ($urandom_range(0, 99) < 5)) begin
        wb_valid = ($urandom_range(0, 99) < 50);
        wb_flit = mk_flit(CHI_REQ_WRITENOSNPFULL, wb_txn); wb_txn++;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hnf_txreq_arb.md
HNF_TXREQ_ARB -- requirements
Module: hnf_txreq_arb

Interface
REQ-001 Parameter MAX_CRD, default 15: maximum TXREQ link credits the receiver may grant.
REQ-002 Parameter CRD_W, default 4: credit counter width; SHALL satisfy 2**CRD_W > MAX_CRD.
REQ-003 clock  input  1  single clock; every flop in the block is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rd_valid  input  1  read path (ReadNoSnp, miss/DMT) has a request flit.
REQ-006 rd_flit  input  reqflit_t  read path request flit; held stable while rd_valid is high and rd_ready is low.
REQ-007 rd_ready  output  1  read path flit accepted this cycle.
REQ-008 wb_valid  input  1  writeback path (WriteNoSnp, eviction) has a request flit.
REQ-009 wb_flit  input  reqflit_t  writeback path request flit; same hold rule as rd_flit.
REQ-010 wb_ready  output  1  writeback path flit accepted this cycle.
REQ-011 TXREQFLIT  output  reqflit_t  registered flit to the SNF.
REQ-012 TXREQFLITV  output  1  registered flit valid.
REQ-013 TXREQFLITPEND  output  1  flit may be sent next cycle.
REQ-014 TXREQLCRDV  input  1  one link credit returned by the receiver.
REQ-015 crd_cnt  output  CRD_W  current credit count, for debug and performance counters.
REQ-016 crd_err  output  1  sticky flag: a credit arrived while the count was already MAX_CRD.

Function
REQ-017 Credit count: +1 on a TXREQLCRDV cycle; -1 on a TXREQFLITV cycle; unchanged when both or neither occur.
REQ-018 Saturation: TXREQLCRDV with crd_cnt==MAX_CRD and no TXREQFLITV leaves the count at MAX_CRD and sets crd_err.
REQ-019 Grant eligibility: crd_cnt>0, minus one if TXREQFLITV is high this cycle. A credit arriving in cycle N is usable from cycle N+1; it SHALL NOT enable a same-cycle grant.
REQ-020 Grant: at most one grant per cycle. rd_ready or wb_ready is high only if that requester's valid is high and the grant is eligible.
REQ-021 Arbitration: round-robin with a 1-bit priority pointer, reset to rd. With both valid, the prioritised requester wins. After any grant the pointer moves to the other requester.
REQ-022 A lone valid requester SHALL win regardless of the pointer; the pointer still updates.
REQ-023 Latency: a flit granted in cycle N appears on TXREQFLIT with TXREQFLITV=1 in cycle N+1, exactly one cycle long.
REQ-024 Back-to-back: grants in consecutive cycles are allowed while credits remain, giving a flit every cycle.
REQ-025 TXREQFLITPEND = rd_valid OR wb_valid, combinational, so PEND is high in the grant cycle one cycle before FLITV.
REQ-026 TXREQFLIT holds its last value when TXREQFLITV=0; receivers SHALL ignore it.
REQ-027 No grant occurs with crd_cnt==0, even if TXREQLCRDV is high in that cycle.
REQ-028 A requester may drop valid without a grant; no state changes result.

Reset
REQ-029 During reset: TXREQFLITV=0, TXREQFLIT='0, crd_cnt=0, crd_err=0, pointer=rd, rd_ready=wb_ready=0.
REQ-030 A flit granted in the cycle reset is asserted SHALL NOT be emitted.
REQ-031 Credits held when reset is asserted are discarded; the link partner re-grants them after reset.

Structure
REQ-032 reqflit_t, MAX_CRD and the CHI REQ opcode constants (ReadNoSnp, WriteNoSnp) SHALL come from the shared CHI package, not local definitions.
REQ-033 One sub-module, chi_lcrd_counter, holds the credit counter (increment, decrement, saturation, error flag). The round-robin arbiter and the output register are inline.
REQ-034 Simulation-only assertions: no FLITV while crd_cnt==0; ready only with valid; rd_ready and wb_ready never both high.

Verification
REQ-035 After reset, 3 TXREQLCRDV pulses, then rd_valid held for 5 cycles -> exactly 3 FLITV in consecutive cycles, crd_cnt reaches 0, rd_ready low afterwards.
REQ-036 crd_cnt=4, rd and wb both valid continuously -> flits alternate rd,wb,rd,wb; TxnIDs match the sources.
REQ-037 crd_cnt=1, TXREQLCRDV and FLITV in the same cycle -> crd_cnt stays 1 and the next grant happens in the following cycle.
REQ-038 crd_cnt=0, rd_valid high, TXREQLCRDV pulse in cycle N -> rd_ready in N+1, FLITV in N+2, PEND high in N+1.
REQ-039 Drive 16 credits with no requests and MAX_CRD=15 -> crd_cnt=15, crd_err=1, still set 10 cycles later.
REQ-040 Assert reset in the cycle a grant is issued -> no FLITV in the next cycle, crd_cnt=0, pointer=rd.
